// File: rtl/dmem_port_arbiter_pkg.sv
// dmem_port_arbiter_pkg: funct3 codes, FSM encoding, byte-enable constants and access sizing
package dmem_port_arbiter_pkg;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY_IF  = 2'd1,
        ST_BUSY_MEM = 2'd2
    } state_e;
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;
    // Undefined funct3 codes fall through to a word access.
    function automatic size_e access_size(input logic [2:0] f3, input logic store);
        if (store)
            return f3 == F3_SW ? SZ_WORD : f3 == F3_SB ? SZ_BYTE : f3 == F3_SH ? SZ_HALF : SZ_WORD;
        return f3 == F3_LW ? SZ_WORD : (f3 == F3_LB || f3 == F3_LBU) ? SZ_BYTE :
               (f3 == F3_LH || f3 == F3_LHU) ? SZ_HALF : SZ_WORD;
    endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte enables, store lane replication, load right-alignment and misalignment detect
module dmem_lane_align
    import dmem_port_arbiter_pkg::*;
(
    input  logic [2:0]  type_i,
    input  logic [1:0]  addr_i,
    input  logic        store_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o
);
    size_e size;
    assign size = access_size(type_i, store_i);
    assign be_o = (!store_i || size == SZ_WORD) ? BE_WORD :
                  size == SZ_HALF ? BE_HALF << {addr_i[1], 1'b0} : BE_BYTE << addr_i;
    assign wdata_o = size == SZ_BYTE ? {4{wdata_i[7:0]}} :
                     size == SZ_HALF ? {2{wdata_i[15:0]}} : wdata_i;
    assign rdata_o = rdata_i >> {addr_i, 3'b000};
    assign misaligned_o = size == SZ_HALF ? addr_i[0] : size == SZ_WORD ? |addr_i : 1'b0;
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: grants IF or MEM-stage requests onto one wait-stated req/ack memory bus,
// MEM first; misaligned MEM accesses complete without a bus cycle.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              mem_req_rd,
    input  logic              mem_req_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [2:0]        mem_type,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              misaligned,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [3:0]        bus_be,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack
);
    state_e            state_q, state_d;
    logic              bus_req_q, bus_req_d, bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
    logic              if_valid_q, if_valid_d, mem_done_q, mem_done_d, misaligned_q, misaligned_d;
    logic [1:0]        a_q, a_d;
    logic              mem_elig, if_elig, lane_mis;
    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata, lane_rdata;
    // A requester whose completion pulse is still high must not be granted again.
    assign mem_elig = (mem_req_rd | mem_req_wr) & ~mem_done_q;
    assign if_elig  = if_req & ~if_valid_q;
    dmem_lane_align u_lane (
        .type_i       (mem_type),
        .addr_i       (state_q == ST_BUSY_MEM ? a_q : mem_addr[1:0]),
        .store_i      (mem_req_wr),
        .wdata_i      (mem_wdata),
        .rdata_i      (bus_rdata),
        .be_o         (lane_be),
        .wdata_o      (lane_wdata),
        .rdata_o      (lane_rdata),
        .misaligned_o (lane_mis)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_be_q     <= '0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
            if_valid_q   <= 1'b0;
            mem_done_q   <= 1'b0;
            misaligned_q <= 1'b0;
            a_q          <= '0;
        end else begin
            state_q      <= state_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_be_q     <= bus_be_d;
            if_rdata_q   <= if_rdata_d;
            mem_rdata_q  <= mem_rdata_d;
            if_valid_q   <= if_valid_d;
            mem_done_q   <= mem_done_d;
            misaligned_q <= misaligned_d;
            a_q          <= a_d;
        end
    end
    always_comb begin
        state_d      = state_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_be_d     = bus_be_q;
        if_rdata_d   = if_rdata_q;
        mem_rdata_d  = mem_rdata_q;
        a_d          = a_q;
        if_valid_d   = 1'b0;
        mem_done_d   = 1'b0;
        misaligned_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_elig && lane_mis) begin
                    mem_done_d   = 1'b1;
                    misaligned_d = 1'b1;
                    mem_rdata_d  = '0;
                end else if (mem_elig) begin
                    state_d     = ST_BUSY_MEM;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_req_wr;
                    bus_addr_d  = mem_addr & ~ADDR_W'(3);
                    bus_wdata_d = mem_req_wr ? lane_wdata : '0;
                    bus_be_d    = lane_be;
                    a_d         = mem_addr[1:0];
                end else if (if_elig) begin
                    state_d     = ST_BUSY_IF;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = if_addr & ~ADDR_W'(3);
                    bus_wdata_d = '0;
                    bus_be_d    = BE_WORD;
                end
            end
            ST_BUSY_IF: begin
                if (bus_ack) begin
                    state_d    = ST_IDLE;
                    bus_req_d  = 1'b0;
                    if_rdata_d = bus_rdata;
                    if_valid_d = 1'b1;
                end
            end
            ST_BUSY_MEM: begin
                if (bus_ack) begin
                    state_d     = ST_IDLE;
                    bus_req_d   = 1'b0;
                    mem_rdata_d = bus_we_q ? mem_rdata_q : lane_rdata;
                    mem_done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end
    assign if_rdata   = if_rdata_q;
    assign if_valid   = if_valid_q;
    assign mem_rdata  = mem_rdata_q;
    assign mem_done   = mem_done_q;
    assign misaligned = misaligned_q;
    assign stall_if   = if_req & ~if_valid_q;
    assign stall_mem  = (mem_req_rd | mem_req_wr) & ~mem_done_q;
    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign bus_be     = bus_be_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed and random IF/MEM traffic against a byte-array memory reference
module tb_dmem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        mem_req_rd = 1'b0, mem_req_wr = 1'b0;
    logic [31:0] mem_addr = '0, mem_wdata = '0;
    logic [2:0]  mem_type = '0;
    logic [31:0] mem_rdata;
    logic        mem_done, misaligned, stall_if, stall_mem;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic [31:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;
    always #5 clk = ~clk;
    dmem_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .mem_req_rd(mem_req_rd), .mem_req_wr(mem_req_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_type(mem_type), .mem_rdata(mem_rdata),
        .mem_done(mem_done), .misaligned(misaligned),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_be(bus_be), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );
    int checks = 0, failures = 0;
    logic [7:0] mem_b [256];
    logic [7:0] ref_b [256];
    int ack_dly = 0, wait_cnt = 0, n_bus_wr = 0, n_grant = 0;
    logic prev_req = 1'b0;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask
    function automatic logic [31:0] ref_word(input int base);
        return {ref_b[base+3], ref_b[base+2], ref_b[base+1], ref_b[base]};
    endfunction
    task automatic poke_word(input int base, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            mem_b[base+i] = w[8*i +: 8];
            ref_b[base+i] = w[8*i +: 8];
        end
    endtask
    // One clock; then the memory model answers the bus for the coming edge.
    task automatic tick();
        int ba;
        @(negedge clk);
        if (bus_req && !prev_req) n_grant++;
        prev_req = bus_req;
        bus_ack = 1'b0;
        bus_rdata = $urandom();
        if (bus_req) begin
            if (wait_cnt >= ack_dly) begin
                ba = int'(bus_addr[7:0]);
                bus_ack = 1'b1;
                wait_cnt = 0;
                bus_rdata = {mem_b[ba+3], mem_b[ba+2], mem_b[ba+1], mem_b[ba]};
                if (bus_we) begin
                    n_bus_wr++;
                    for (int b = 0; b < 4; b++) if (bus_be[b]) mem_b[ba+b] = bus_wdata[8*b +: 8];
                end
            end else wait_cnt++;
        end else wait_cnt = 0;
    endtask
    task automatic mem_op(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [2:0] f3, input int dly);
        int sz, a, base, lat, stalls, wr0;
        bit mis, seen, bus_chk;
        logic [31:0] exp_rd, exp_be, exp_wd;
        a = int'(addr[1:0]);
        base = int'(addr[7:0]) & 252;
        if (wr) sz = f3 == 3'd0 ? 1 : f3 == 3'd1 ? 2 : 4;
        else sz = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
        mis = (a % sz) != 0;
        exp_rd = '0;
        exp_be = '0;
        exp_wd = sz == 1 ? {4{wd[7:0]}} : sz == 2 ? {2{wd[15:0]}} : wd;
        if (!wr && !mis) for (int i = 0; i < 4 - a; i++) exp_rd |= 32'(ref_b[base+a+i]) << (8*i);
        if (wr && !mis) for (int i = 0; i < sz; i++) begin
            exp_be |= 32'(1) << (a + i);
            ref_b[base+a+i] = wd[8*i +: 8];
        end
        ack_dly = dly;
        wr0 = n_bus_wr;
        mem_addr = addr; mem_wdata = wd; mem_type = f3;
        mem_req_wr = wr; mem_req_rd = !wr;
        #1;
        stalls = stall_mem ? 1 : 0;
        lat = 0; seen = 0; bus_chk = 0;
        while (!seen && lat < 40) begin
            tick();
            lat++;
            if (bus_req && !bus_chk) begin
                bus_chk = 1;
                check("bus_addr", bus_addr, addr & ~32'd3);
                check("bus_we", bus_we, wr);
                check("bus_be", bus_be, wr ? exp_be : 32'hF);
                if (wr) check("bus_wdata", bus_wdata, exp_wd);
            end
            if (mem_done) seen = 1;
            else if (stall_mem) stalls++;
        end
        check("mem_done_seen", seen, 1);
        check("mem_latency", lat, mis ? 1 : 2 + dly);
        check("stall_mem_cycles", stalls, lat);
        check("stall_mem_at_done", stall_mem, 0);
        check("misaligned", misaligned, mis);
        check("bus_cycle_issued", bus_chk, !mis);
        check("bus_writes", n_bus_wr - wr0, (wr && !mis) ? 1 : 0);
        if (!wr || mis) check("mem_rdata", mem_rdata, exp_rd);
        if (wr) check("mem_word", {mem_b[base+3], mem_b[base+2], mem_b[base+1], mem_b[base]}, ref_word(base));
        mem_req_rd = 0; mem_req_wr = 0;
        tick();
        check("mem_done_single", {mem_done, misaligned}, 0);
        if (!wr || mis) check("mem_rdata_held", mem_rdata, exp_rd);
    endtask
    task automatic if_op(input logic [31:0] addr, input int dly);
        int lat;
        bit seen;
        logic [31:0] exp;
        exp = ref_word(int'(addr[7:0]));
        ack_dly = dly;
        if_addr = addr; if_req = 1;
        #1;
        check("stall_if_req", stall_if, 1);
        lat = 0; seen = 0;
        while (!seen && lat < 40) begin
            tick();
            lat++;
            if (if_valid) seen = 1;
        end
        check("if_valid_seen", seen, 1);
        check("if_latency", lat, 2 + dly);
        check("if_rdata", if_rdata, exp);
        check("stall_if_at_valid", stall_if, 0);
        if_req = 0;
        tick();
        check("if_valid_single", if_valid, 0);
        check("if_rdata_held", if_rdata, exp);
    endtask
    initial begin
        int md_cnt, md_cyc, iv_cyc, g0;
        logic [31:0] w;
        for (int i = 0; i < 256; i++) begin
            w[7:0] = 8'($urandom());
            mem_b[i] = w[7:0];
            ref_b[i] = w[7:0];
        end
        repeat (2) @(negedge clk);
        check("reset_bus", {bus_req, bus_we, bus_be}, 0);
        check("reset_bus_addr", bus_addr, 0);
        check("reset_bus_wdata", bus_wdata, 0);
        check("reset_pulses", {if_valid, mem_done, misaligned}, 0);
        check("reset_rdata", if_rdata | mem_rdata, 0);
        rst_n = 1;
        tick();
        // SB to 0x1003, ack withheld 3 cycles
        mem_op(1, 32'h1003, 32'h0000_00AB, 3'b000, 3);
        // LH from 0x2002, immediate ack
        poke_word(0, 32'h8001_1234);
        mem_op(0, 32'h2002, 32'h0, 3'b001, 0);
        check("lh_value", mem_rdata, 32'h0000_8001);
        // Misaligned SW: no bus cycle
        mem_op(1, 32'h3002, 32'hDEAD_BEEF, 3'b010, 0);
        // Spurious ack while idle is ignored
        bus_ack = 1;
        @(negedge clk);
        @(negedge clk);
        check("stray_ack", {bus_req, if_valid, mem_done}, 0);
        bus_ack = 0;
        // Simultaneous IF and MEM requests: MEM first
        poke_word(64, 32'h1122_3344);
        poke_word(128, 32'h5566_7788);
        ack_dly = 0;
        g0 = n_grant;
        md_cnt = 0; md_cyc = 0; iv_cyc = 0;
        mem_addr = 32'h40; mem_type = 3'b010; mem_req_rd = 1;
        if_addr = 32'h80; if_req = 1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (mem_done) begin md_cnt++; md_cyc = c; mem_req_rd = 0; end
            if (if_valid) begin iv_cyc = c; if_req = 0; end
        end
        check("both_mem_done_cyc", md_cyc, 2);
        check("both_if_valid_cyc", iv_cyc, 4);
        check("both_mem_done_count", md_cnt, 1);
        check("both_grants", n_grant - g0, 2);
        check("both_mem_rdata", mem_rdata, 32'h1122_3344);
        check("both_if_rdata", if_rdata, 32'h5566_7788);
        // Reset in BUSY_IF with ack withheld
        ack_dly = 1000;
        if_addr = 32'h10; if_req = 1;
        repeat (3) tick();
        check("pre_reset_bus_req", bus_req, 1);
        #2 rst_n = 0;
        #1;
        check("async_bus_req", {bus_req, bus_we, bus_be}, 0);
        check("async_bus_addr", bus_addr, 0);
        check("async_pulses", {if_valid, mem_done, misaligned}, 0);
        check("async_rdata", if_rdata | mem_rdata, 0);
        if_req = 0;
        ack_dly = 0;
        repeat (2) tick();
        rst_n = 1;
        tick();
        if_op(32'h0, 0);
        // Random mixed traffic
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 2))
                0: if_op(32'($urandom_range(0, 63)) * 4, $urandom_range(0, 3));
                1: mem_op(0, 32'($urandom_range(0, 255)), 32'h0, 3'($urandom_range(0, 7)), $urandom_range(0, 3));
                default: mem_op(1, 32'($urandom_range(0, 255)), $urandom(), 3'($urandom_range(0, 3)), $urandom_range(0, 3));
            endcase
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
